gpu_memory_ctrl: RTL and testbench

Operand-storage unit for a GPU warp. It serves one request at a time to either a 16-entry register bank or a 256-word backing memory. The memory path sits behind a small direct-mapped, write-through cache. The warp's operand-fetch stage drives the request strobes; this block returns data plus valid/hit/error status.

---
 rtl/gpu_memory_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_gpu_memory_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_memory_ctrl.sv
// gpu_memory_ctrl
//   Operand-storage unit for one GPU warp. Serves one request at a time to
//   either a register bank or a backing memory. The memory path goes through
//   a direct-mapped, one-word-per-line, write-through/no-allocate cache.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   register request targets the register bank
//   memory   request targets backing memory through the cache
//   read     read strobe
//   write    write strobe
//   addr     word address (register index uses the low bits)
//   wdata    write data
//   rdata    read data, held between responses
//   valid    one-cycle response pulse
//   hit      cache-hit flag, qualified by valid
//   busy     read miss in flight; new requests are dropped
//   error    illegal-request flag, qualified by valid
module gpu_memory_ctrl #(
   parameter int DATA_W    = 64,
   parameter int REG_DEPTH = 16,
   parameter int MEM_AW    = 8,
   parameter int LINES     = 4,
   parameter int MISS_LAT  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              register,
   input  logic              memory,
   input  logic              read,
   input  logic              write,
   input  logic [MEM_AW-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              valid,
   output logic              hit,
   output logic              busy,
   output logic              error
);

   localparam int RIDX_W = $clog2(REG_DEPTH);
   localparam int IDX_W  = $clog2(LINES);
   localparam int TAG_W  = MEM_AW - IDX_W;
   localparam int CNT_W  = $clog2(MISS_LAT);

   typedef enum logic {
      IDLE = 1'b0,
      MISS = 1'b1
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [MEM_AW-1:0]   miss_addr;

   logic [DATA_W-1:0]   bank [REG_DEPTH];
   logic [DATA_W-1:0]   mem  [2**MEM_AW];
   logic [DATA_W-1:0]   mem_q;

   logic [DATA_W-1:0]   line_data [LINES];
   logic [TAG_W-1:0]    line_tag  [LINES];
   logic [LINES-1:0]    line_valid;
   logic [LINES-1:0]    line_match;

   logic [RIDX_W-1:0]   reg_idx;
   logic [IDX_W-1:0]    line_idx;
   logic [TAG_W-1:0]    addr_tag;
   logic [IDX_W-1:0]    miss_idx;
   logic [TAG_W-1:0]    miss_tag;

   logic                accept;
   logic                illegal;
   logic                tag_hit;
   logic                mem_we;
   logic                mem_re;

   assign reg_idx  = addr[RIDX_W-1:0];
   assign line_idx = addr[IDX_W-1:0];
   assign addr_tag = addr[MEM_AW-1:IDX_W];
   assign miss_idx = miss_addr[IDX_W-1:0];
   assign miss_tag = miss_addr[MEM_AW-1:IDX_W];

   assign accept  = (register | memory) & (read | write) & ~busy;
   assign illegal = (register & memory) | (read & write);

   // Per-line tag compare against the incoming address tag; the addressed
   // line's result is the cache hit.
   generate
      for (genvar gi = 0; gi < LINES; gi++) begin : g_match
         assign line_match[gi] = line_valid[gi] && (line_tag[gi] == addr_tag);
      end
   endgenerate
   assign tag_hit = line_match[line_idx];

   assign mem_we = accept & ~illegal & memory & write;
   assign mem_re = accept & ~illegal & memory & read;

   // Backing memory is never reset. The read word is captured at acceptance;
   // no write can be accepted while a miss is in flight, so it stays current.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[addr] <= wdata;
      end
      if (mem_re) begin
         mem_q <= mem[addr];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         miss_addr  <= '0;
         rdata      <= '0;
         valid      <= 1'b0;
         hit        <= 1'b0;
         busy       <= 1'b0;
         error      <= 1'b0;
         line_valid <= '0;
         for (int i = 0; i < REG_DEPTH; i++) begin
            bank[i] <= '0;
         end
         for (int i = 0; i < LINES; i++) begin
            line_data[i] <= '0;
            line_tag[i]  <= '0;
         end
      end else begin
         valid <= 1'b0;
         hit   <= 1'b0;
         error <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (illegal) begin
                     valid <= 1'b1;
                     error <= 1'b1;
                  end else if (register) begin
                     valid <= 1'b1;
                     hit   <= 1'b1;
                     if (read) begin
                        rdata <= bank[reg_idx];
                     end else begin
                        bank[reg_idx] <= wdata;
                     end
                  end else if (read) begin
                     if (tag_hit) begin
                        valid <= 1'b1;
                        hit   <= 1'b1;
                        rdata <= line_data[line_idx];
                     end else begin
                        // Counter runs MISS_LAT-1 edges so the response
                        // lands MISS_LAT cycles after acceptance.
                        state     <= MISS;
                        busy      <= 1'b1;
                        cnt       <= CNT_W'(MISS_LAT - 2);
                        miss_addr <= addr;
                     end
                  end else begin
                     // Write-through, no-allocate: only refresh a matching line.
                     valid <= 1'b1;
                     hit   <= tag_hit;
                     if (tag_hit) begin
                        line_data[line_idx] <= wdata;
                     end
                  end
               end
            end
            MISS: begin
               if (cnt == '0) begin
                  valid                <= 1'b1;
                  rdata                <= mem_q;
                  line_data[miss_idx]  <= mem_q;
                  line_tag[miss_idx]   <= miss_tag;
                  line_valid[miss_idx] <= 1'b1;
                  busy                 <= 1'b0;
                  state                <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gpu_memory_ctrl.sv
// tb_gpu_memory_ctrl
//   Self-checking bench for gpu_memory_ctrl: a directed vector table, a few
//   hand-written multi-cycle sequences (drop while busy, reset mid-miss,
//   back-to-back), then randomized requests checked against a
//   transaction-level reference model.
module tb_gpu_memory_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rg = 1'b0;
   logic        mm = 1'b0;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic [7:0]  addr = '0;
   logic [63:0] wdata = '0;
   logic [63:0] rdata;
   logic        valid;
   logic        hit;
   logic        busy;
   logic        error;

   int checks = 0;
   int failures = 0;

   gpu_memory_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .register (rg),
      .memory   (mm),
      .read     (rd),
      .write    (wr),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .valid    (valid),
      .hit      (hit),
      .busy     (busy),
      .error    (error)
   );

   always #5 clk = ~clk;

   // ---------------- reference model (transaction level) ----------------
   // Write-through means a cached word always equals memory, so the model
   // only tracks which address each line holds, not its data.
   logic [63:0] m_bank [16];
   logic [63:0] m_mem  [256];
   int          m_line [4];
   logic [63:0] m_last;

   function automatic logic [63:0] init_word(input int i);
      return 64'hC0DE_0000_0000_0000 | 64'(i);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_bank[i] = '0;
      for (int i = 0; i < 4; i++) m_line[i] = -1;
      m_last = '0;
   endtask

   task automatic predict(input logic r, m, rdq, wrq, input logic [7:0] a,
                          input logic [63:0] wd, output int lat, output int bsy,
                          output logic h, output logic e, output logic [63:0] d);
      int idx;
      idx = int'(a) % 4;
      lat = 1; bsy = 0; h = 1'b0; e = 1'b0;
      if ((r && m) || (rdq && wrq)) begin
         e = 1'b1;
      end else if (r) begin
         h = 1'b1;
         if (rdq) m_last = m_bank[int'(a) % 16];
         else     m_bank[int'(a) % 16] = wd;
      end else if (rdq) begin
         m_last = m_mem[a];
         if (m_line[idx] == int'(a)) begin
            h = 1'b1;
         end else begin
            lat = 3; bsy = 2;
            m_line[idx] = int'(a);
         end
      end else begin
         m_mem[a] = wd;
         h = (m_line[idx] == int'(a));
      end
      d = m_last;
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   // Drive one request for a single edge, then wait (bounded) for the response.
   task automatic run_txn(input logic r, m, rdq, wrq, input logic [7:0] a,
                          input logic [63:0] wd, output int lat, output int bsy,
                          output int stray, output logic h, output logic e,
                          output logic [63:0] d);
      @(negedge clk);
      rg = r; mm = m; rd = rdq; wr = wrq; addr = a; wdata = wd;
      @(posedge clk);
      #1;
      rg = 1'b0; mm = 1'b0; rd = 1'b0; wr = 1'b0;
      lat = 0; bsy = 0; stray = 0; h = 1'b0; e = 1'b0; d = 'x;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (valid) begin
            lat = c; h = hit; e = error; d = rdata;
            break;
         end
         if (busy) bsy++;
         if (hit || error) stray++;
      end
   endtask

   task automatic do_check(input string tag, input int n,
                           input logic r, m, rdq, wrq, input logic [7:0] a,
                           input logic [63:0] wd, input int xlat, input int xbsy,
                           input logic xh, input logic xe, input logic [63:0] xd);
      int lat, bsy, stray;
      logic h, e;
      logic [63:0] d;
      run_txn(r, m, rdq, wrq, a, wd, lat, bsy, stray, h, e, d);
      $display("txn %s%0d reg=%b mem=%b rd=%b wr=%b a=%h lat=%0d busy=%0d hit=%b err=%b rdata=%h",
               tag, n, r, m, rdq, wrq, a, lat, bsy, h, e, d);
      chk($sformatf("%s%0d latency", tag, n), 64'(lat), 64'(xlat));
      chk($sformatf("%s%0d busy_cycles", tag, n), 64'(bsy), 64'(xbsy));
      chk($sformatf("%s%0d stray_status", tag, n), 64'(stray), 64'd0);
      chk($sformatf("%s%0d hit", tag, n), 64'(h), 64'(xh));
      chk($sformatf("%s%0d error", tag, n), 64'(e), 64'(xe));
      chk($sformatf("%s%0d rdata", tag, n), d, xd);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        r, m, rdq, wrq;
      logic [7:0]  a;
      logic [63:0] wd;
      int          lat, bsy;
      logic        h, e;
      logic [63:0] d;
   } vec_t;

   localparam int NV = 21;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic r, m, rdq, wrq, input logic [7:0] a,
                               input logic [63:0] wd, input int lat, input int bsy,
                               input logic h, input logic e, input logic [63:0] d);
      vec_t v;
      v.r = r; v.m = m; v.rdq = rdq; v.wrq = wrq; v.a = a; v.wd = wd;
      v.lat = lat; v.bsy = bsy; v.h = h; v.e = e; v.d = d;
      return v;
   endfunction

   initial begin
      int lat, bsy, stray, nval;
      logic h, e;
      logic [63:0] d;
      logic [63:0] ones;
      ones = '1;

      //                r  m  rd wr addr   wdata                  lat bsy h  e  rdata
      vecs[0]  = mk(1, 0, 0, 1, 8'h05, 64'hDEAD_BEEF_0000_0001, 1, 0, 1, 0, 64'h0);
      vecs[1]  = mk(1, 0, 1, 0, 8'h05, 64'h0,                   1, 0, 1, 0, 64'hDEAD_BEEF_0000_0001);
      vecs[2]  = mk(1, 0, 1, 0, 8'h06, 64'h0,                   1, 0, 1, 0, 64'h0);
      vecs[3]  = mk(1, 0, 1, 0, 8'hF5, 64'h0,                   1, 0, 1, 0, 64'hDEAD_BEEF_0000_0001);
      vecs[4]  = mk(0, 1, 0, 1, 8'h24, 64'h1234,                1, 0, 0, 0, 64'hDEAD_BEEF_0000_0001);
      vecs[5]  = mk(0, 1, 1, 0, 8'h24, 64'h0,                   3, 2, 0, 0, 64'h1234);
      vecs[6]  = mk(0, 1, 1, 0, 8'h24, 64'h0,                   1, 0, 1, 0, 64'h1234);
      vecs[7]  = mk(0, 1, 0, 1, 8'h24, 64'h5678,                1, 0, 1, 0, 64'h1234);
      vecs[8]  = mk(0, 1, 1, 0, 8'h24, 64'h0,                   1, 0, 1, 0, 64'h5678);
      vecs[9]  = mk(0, 1, 0, 1, 8'h04, 64'h0404,                1, 0, 0, 0, 64'h5678);
      vecs[10] = mk(0, 1, 1, 0, 8'h04, 64'h0,                   3, 2, 0, 0, 64'h0404);
      vecs[11] = mk(0, 1, 1, 0, 8'h24, 64'h0,                   3, 2, 0, 0, 64'h5678);
      vecs[12] = mk(1, 1, 1, 0, 8'h05, 64'h0,                   1, 0, 0, 1, 64'h5678);
      vecs[13] = mk(1, 1, 0, 1, 8'h05, 64'hBAD,                 1, 0, 0, 1, 64'h5678);
      vecs[14] = mk(1, 0, 1, 1, 8'h05, 64'hBAD,                 1, 0, 0, 1, 64'h5678);
      vecs[15] = mk(0, 1, 1, 1, 8'h24, 64'hBAD,                 1, 0, 0, 1, 64'h5678);
      vecs[16] = mk(1, 0, 1, 0, 8'h05, 64'h0,                   1, 0, 1, 0, 64'hDEAD_BEEF_0000_0001);
      vecs[17] = mk(0, 1, 1, 0, 8'h24, 64'h0,                   1, 0, 1, 0, 64'h5678);
      vecs[18] = mk(0, 1, 1, 0, 8'h05, 64'h0,                   3, 2, 0, 0, 64'hC0DE_0000_0000_0005);
      vecs[19] = mk(1, 0, 0, 1, 8'h0F, ones,                    1, 0, 1, 0, 64'hC0DE_0000_0000_0005);
      vecs[20] = mk(1, 0, 1, 0, 8'h0F, 64'h0,                   1, 0, 1, 0, ones);

      // ---- reset state ----
      model_reset();
      repeat (3) @(negedge clk);
      chk("reset rdata", rdata, 64'h0);
      chk("reset valid", 64'(valid), 64'h0);
      chk("reset hit",   64'(hit),   64'h0);
      chk("reset busy",  64'(busy),  64'h0);
      chk("reset error", 64'(error), 64'h0);
      rst = 1'b0;

      // ---- preload backing memory so every later read is defined ----
      for (int i = 0; i < 256; i++) begin
         run_txn(1'b0, 1'b1, 1'b0, 1'b1, 8'(i), init_word(i), lat, bsy, stray, h, e, d);
         m_mem[i] = init_word(i);
      end
      chk("preload last latency", 64'(lat), 64'd1);

      // ---- directed table ----
      for (int i = 0; i < NV; i++) begin
         int pl, pb;
         logic ph, pe;
         logic [63:0] pd;
         predict(vecs[i].r, vecs[i].m, vecs[i].rdq, vecs[i].wrq, vecs[i].a, vecs[i].wd,
                 pl, pb, ph, pe, pd);
         do_check("vec", i, vecs[i].r, vecs[i].m, vecs[i].rdq, vecs[i].wrq, vecs[i].a,
                  vecs[i].wd, vecs[i].lat, vecs[i].bsy, vecs[i].h, vecs[i].e, vecs[i].d);
      end

      // ---- requests during busy are dropped ----
      begin
         int pl, pb;
         logic ph, pe;
         logic [63:0] pd, got;
         int vcyc;
         predict(1'b0, 1'b1, 1'b1, 1'b0, 8'h31, 64'h0, pl, pb, ph, pe, pd);
         @(negedge clk);
         rg = 1'b0; mm = 1'b1; rd = 1'b1; wr = 1'b0; addr = 8'h31;
         @(posedge clk);
         #1;
         rg = 1'b1; mm = 1'b0; rd = 1'b1; addr = 8'h05;
         nval = 0; vcyc = 0; got = '0;
         for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (valid) begin
               nval++;
               vcyc = c;
               got = rdata;
            end
            if (c == 2) begin
               rg = 1'b0; mm = 1'b0; rd = 1'b0;
            end
         end
         $display("txn busy_drop a=31 pulses=%0d at_cycle=%0d rdata=%h", nval, vcyc, got);
         chk("busy_drop pulses", 64'(nval), 64'd1);
         chk("busy_drop cycle", 64'(vcyc), 64'(pl));
         chk("busy_drop rdata", got, pd);
      end

      // ---- back-to-back register reads ----
      begin
         int pl, pb;
         logic ph, pe;
         logic [63:0] pd;
         logic v1, v2, v3;
         predict(1'b1, 1'b0, 1'b1, 1'b0, 8'h0F, 64'h0, pl, pb, ph, pe, pd);
         predict(1'b1, 1'b0, 1'b1, 1'b0, 8'h0F, 64'h0, pl, pb, ph, pe, pd);
         @(negedge clk);
         rg = 1'b1; mm = 1'b0; rd = 1'b1; wr = 1'b0; addr = 8'h0F;
         @(negedge clk);
         v1 = valid;
         @(posedge clk);
         #1;
         rg = 1'b0; rd = 1'b0;
         @(negedge clk);
         v2 = valid;
         d = rdata;
         @(negedge clk);
         v3 = valid;
         $display("txn back_to_back a=0f valid=%b%b%b rdata=%h", v1, v2, v3, d);
         chk("b2b first valid", 64'(v1), 64'd1);
         chk("b2b second valid", 64'(v2), 64'd1);
         chk("b2b third valid", 64'(v3), 64'd0);
         chk("b2b rdata", d, pd);
      end

      // ---- reset during the second busy cycle of a miss ----
      begin
         logic b2;
         @(negedge clk);
         mm = 1'b1; rd = 1'b1; addr = 8'h39;
         @(posedge clk);
         #1;
         mm = 1'b0; rd = 1'b0;
         @(negedge clk);
         @(negedge clk);
         b2 = busy;
         rst = 1'b1;
         #1;
         $display("txn reset_mid_miss a=39 busy_before=%b busy=%b valid=%b rdata=%h", b2, busy, valid, rdata);
         chk("midreset busy_before", 64'(b2), 64'd1);
         chk("midreset busy", 64'(busy), 64'd0);
         chk("midreset valid", 64'(valid), 64'd0);
         chk("midreset rdata", rdata, 64'h0);
         repeat (2) @(negedge clk);
         rst = 1'b0;
         model_reset();
         nval = 0;
         for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (valid) nval++;
         end
         chk("midreset no_response", 64'(nval), 64'd0);
      end

      begin
         int pl, pb;
         logic ph, pe;
         logic [63:0] pd;
         predict(1'b1, 1'b0, 1'b1, 1'b0, 8'h05, 64'h0, pl, pb, ph, pe, pd);
         do_check("post_reset", 0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h05, 64'h0, pl, pb, ph, pe, pd);
         predict(1'b0, 1'b1, 1'b1, 1'b0, 8'h39, 64'h0, pl, pb, ph, pe, pd);
         do_check("post_reset", 1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h39, 64'h0, pl, pb, ph, pe, pd);
      end

      // ---- randomized requests against the model ----
      for (int n = 0; n < 300; n++) begin
         logic r, m, rdq, wrq;
         logic [7:0] a;
         logic [63:0] wd;
         int k, pl, pb;
         logic ph, pe;
         logic [63:0] pd;
         k = $urandom_range(0, 99);
         if (k < 8) begin
            if ($urandom_range(0, 1) == 1) begin
               r = 1'b1; m = 1'b1; rdq = 1'b1; wrq = 1'($urandom_range(0, 1));
            end else begin
               r = 1'($urandom_range(0, 1)); m = ~r; rdq = 1'b1; wrq = 1'b1;
            end
         end else begin
            r = (k < 35);
            m = ~r;
            rdq = 1'($urandom_range(0, 1));
            wrq = ~rdq;
         end
         if (r || $urandom_range(0, 3) == 0) a = 8'($urandom_range(0, 255));
         else                                a = 8'($urandom_range(0, 15));
         wd = {32'($urandom), 32'($urandom)};
         predict(r, m, rdq, wrq, a, wd, pl, pb, ph, pe, pd);
         do_check("rnd", n, r, m, rdq, wrq, a, wd, pl, pb, ph, pe, pd);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
